// File: rtl/pc_seq_pkg.sv
// Shared types for the next-PC sequencer: FSM state encoding,
// next-PC source codes and the default halt trap address.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } pc_state_e;

    typedef enum logic [1:0] {
        SRC_SEQ = 2'b00,
        SRC_BR  = 2'b01,
        SRC_J   = 2'b10,
        SRC_JR  = 2'b11
    } pc_src_e;

    localparam logic [31:0] DEFAULT_HALT_ADDR = 32'h0000_007C;

endpackage

// File: rtl/pc_target_mux.sv
// Combinational next-PC target select: pc_plus, branch, jump, register jump.
// In: pc, branch/jump request lines and operands. Out: target, src code.
module pc_target_mux
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] pc_inc = 32'd4
) (
    input  logic [31:0] pc,
    input  logic        branch_taken,
    input  logic [31:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        jump_reg,
    input  logic [31:0] jr_addr,
    output logic [31:0] target,
    output pc_src_e     src
);

    logic [31:0] pc_plus;
    logic [31:0] br_target;
    logic [31:0] j_target;

    assign pc_plus   = pc + pc_inc;
    // Word offset to byte offset; top two offset bits fall off (mod 2^32).
    assign br_target = pc_plus + {branch_offset[29:0], 2'b00};
    assign j_target  = {pc_plus[31:28], jump_index, 2'b00};

    always_comb begin
        target = pc_plus;
        src    = SRC_SEQ;
        if (jump_reg) begin
            target = jr_addr;
            src    = SRC_JR;
        end else if (jump) begin
            target = j_target;
            src    = SRC_J;
        end else if (branch_taken) begin
            target = br_target;
            src    = SRC_BR;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller: BOOT/RUN/HALT FSM, alignment fault, load counter.
// In: clk, reset (async high), pc, stall, branch/jump requests.
// Out: target, pc_load, redirect (comb); halted, align_err, instr_count (reg).
// Optional halt-address stop enabled by macro PC_SEQ_HALT_DETECT_EN.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] pc_inc       = 32'd4,
    parameter logic [31:0] halt_address = DEFAULT_HALT_ADDR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        jump_reg,
    input  logic [31:0] jr_addr,
    output logic [31:0] target,
    output logic        pc_load,
    output logic        redirect,
    output logic        halted,
    output logic        align_err,
    output logic [31:0] instr_count
);

`ifdef PC_SEQ_HALT_DETECT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    pc_state_e   state_q, state_d;
    logic        align_err_q, align_err_d;
    logic [31:0] count_q, count_d;

    logic [31:0] mux_target;
    pc_src_e     mux_src;

    pc_target_mux #(
        .pc_inc (pc_inc)
    ) u_mux (
        .pc            (pc),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jump          (jump),
        .jump_index    (jump_index),
        .jump_reg      (jump_reg),
        .jr_addr       (jr_addr),
        .target        (mux_target),
        .src           (mux_src)
    );

    always_comb begin
        state_d     = state_q;
        align_err_d = align_err_q;
        count_d     = count_q;
        target      = 32'd0;
        pc_load     = 1'b0;
        redirect    = 1'b0;
        unique case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                target = mux_target;
                if (!stall) begin
                    if (mux_target[1:0] != 2'b00) begin
                        // Misaligned: suppress the load and trap.
                        align_err_d = 1'b1;
                        state_d     = ST_HALT;
                    end else begin
                        pc_load  = 1'b1;
                        redirect = (mux_src != SRC_SEQ);
                        count_d  = count_q + 32'd1;
                        if (HALT_EN && (mux_target == halt_address)) begin
                            state_d = ST_HALT;
                        end
                    end
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_BOOT;
            align_err_q <= 1'b0;
            count_q     <= 32'd0;
        end else begin
            state_q     <= state_d;
            align_err_q <= align_err_d;
            count_q     <= count_d;
        end
    end

    assign halted      = (state_q == ST_HALT);
    assign align_err   = align_err_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer.
// Expected values are hand-computed; halt-detect expectations follow the macro.
module tb_pc_sequencer;

`ifdef PC_SEQ_HALT_DETECT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_offset;
    logic        jump;
    logic [25:0] jump_index;
    logic        jump_reg;
    logic [31:0] jr_addr;
    logic [31:0] target;
    logic        pc_load;
    logic        redirect;
    logic        halted;
    logic        align_err;
    logic [31:0] instr_count;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .pc            (pc),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jump          (jump),
        .jump_index    (jump_index),
        .jump_reg      (jump_reg),
        .jr_addr       (jr_addr),
        .target        (target),
        .pc_load       (pc_load),
        .redirect      (redirect),
        .halted        (halted),
        .align_err     (align_err),
        .instr_count   (instr_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic clr_in();
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_offset = 32'd0;
        jump          = 1'b0;
        jump_index    = 26'd0;
        jump_reg      = 1'b0;
        jr_addr       = 32'd0;
    endtask

    task automatic next();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        pc    = 32'd0;
        clr_in();
        repeat (3) @(posedge clk);
        next();
        #1;
        chk("rst_pc_load", {31'd0, pc_load}, 32'd0);
        chk("rst_target", target, 32'd0);
        chk("rst_redirect", {31'd0, redirect}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_align", {31'd0, align_err}, 32'd0);
        chk("rst_count", instr_count, 32'd0);

        // Boot cycle
        reset = 1'b0;
        #1;
        chk("boot_pc_load", {31'd0, pc_load}, 32'd0);
        chk("boot_target", target, 32'd0);

        // First RUN cycle
        next(); pc = 32'd0; #1;
        chk("run0_pc_load", {31'd0, pc_load}, 32'd1);
        chk("run0_target", target, 32'd4);
        chk("run0_redirect", {31'd0, redirect}, 32'd0);
        chk("run0_count", instr_count, 32'd0);

        next(); pc = 32'd4; #1;
        chk("run1_count", instr_count, 32'd1);
        chk("run1_target", target, 32'd8);

        // Backward branch
        next(); pc = 32'h40; branch_taken = 1'b1;
        branch_offset = -32'sd2; #1;
        chk("br_count", instr_count, 32'd2);
        chk("br_target", target, 32'h3C);
        chk("br_redirect", {31'd0, redirect}, 32'd1);

        // Direct jump
        next(); branch_taken = 1'b0; jump = 1'b1;
        jump_index = 26'h10; #1;
        chk("j_count", instr_count, 32'd3);
        chk("j_target", target, 32'h40);
        chk("j_redirect", {31'd0, redirect}, 32'd1);

        // All three requests: register jump wins
        next(); jump_reg = 1'b1; jr_addr = 32'h100;
        branch_taken = 1'b1; #1;
        chk("jr_count", instr_count, 32'd4);
        chk("jr_target", target, 32'h100);
        chk("jr_redirect", {31'd0, redirect}, 32'd1);

        // Stall for three cycles
        for (int i = 0; i < 3; i++) begin
            next(); stall = 1'b1; #1;
            chk("stall_pc_load", {31'd0, pc_load}, 32'd0);
            chk("stall_redirect", {31'd0, redirect}, 32'd0);
            chk("stall_count", instr_count, 32'd5);
        end
        next(); stall = 1'b0; #1;
        chk("unstall_pc_load", {31'd0, pc_load}, 32'd1);
        chk("unstall_target", target, 32'h100);
        chk("unstall_count", instr_count, 32'd5);

        // Wrap of pc_plus
        next(); clr_in(); pc = 32'hFFFF_FFFC; #1;
        chk("wrap_count", instr_count, 32'd6);
        chk("wrap_target", target, 32'd0);
        chk("wrap_redirect", {31'd0, redirect}, 32'd0);

        // Jump keeps pc_plus upper nibble
        next(); pc = 32'hF000_0000; jump = 1'b1;
        jump_index = 26'h3FF_FFFF; #1;
        chk("jhi_target", target, 32'hFFFF_FFFC);

        // Sequential run into the halt address
        next(); clr_in(); pc = 32'h78; #1;
        chk("h0_count", instr_count, 32'd8);
        chk("h0_target", target, 32'h7C);
        chk("h0_pc_load", {31'd0, pc_load}, 32'd1);

        next(); pc = 32'h7C; #1;
        chk("h1_count", instr_count, 32'd9);
        chk("h1_halted", {31'd0, halted}, {31'd0, HALT_EN});
        chk("h1_pc_load", {31'd0, pc_load}, {31'd0, !HALT_EN});
        chk("h1_target", target, HALT_EN ? 32'd0 : 32'h80);

        next(); #1;
        chk("h2_count", instr_count, HALT_EN ? 32'd9 : 32'd10);

        // Asynchronous reset between edges
        #2; reset = 1'b1; #1;
        chk("ar_count", instr_count, 32'd0);
        chk("ar_pc_load", {31'd0, pc_load}, 32'd0);
        chk("ar_halted", {31'd0, halted}, 32'd0);
        chk("ar_target", target, 32'd0);

        next(); reset = 1'b0; pc = 32'd0; #1;
        chk("ar_boot_pc_load", {31'd0, pc_load}, 32'd0);

        // Misaligned register jump
        next(); jump_reg = 1'b1; jr_addr = 32'h102; #1;
        chk("al_pc_load", {31'd0, pc_load}, 32'd0);
        chk("al_redirect", {31'd0, redirect}, 32'd0);
        chk("al_err_pre", {31'd0, align_err}, 32'd0);

        next(); jump_reg = 1'b0; jump = 1'b1; #1;
        chk("al_err", {31'd0, align_err}, 32'd1);
        chk("al_halted", {31'd0, halted}, 32'd1);
        chk("al_hold_load", {31'd0, pc_load}, 32'd0);

        next(); clr_in(); #1;
        chk("al_stay_halted", {31'd0, halted}, 32'd1);
        chk("al_stay_load", {31'd0, pc_load}, 32'd0);
        chk("al_count", instr_count, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vec_cnt, err_cnt);
        $finish;
    end

endmodule
